// File: rtl/switch_pkg.sv
// ---------------------------------------------------------------------------
// switch_pkg
// Shared types for the chiplet switch allocator.
//
// Contents:
//   DEF_*      default sizing of the switch (ports, VCs, buffer depth)
//   outport_t  output port index
//   inport_t   input port index
//   vc_t       virtual channel index
//   credit_t   downstream credit counter, wide enough to hold BUFFER_DEPTH
//   lock_t     wormhole lock held by an outport for the duration of a packet
// ---------------------------------------------------------------------------
package switch_pkg;

  localparam int DEF_NUM_INPORTS  = 4;
  localparam int DEF_NUM_OUTPORTS = 4;
  localparam int DEF_NUM_VCS      = 2;
  localparam int DEF_BUFFER_DEPTH = 8;

  localparam int INPORT_W  = $clog2(DEF_NUM_INPORTS);
  localparam int OUTPORT_W = $clog2(DEF_NUM_OUTPORTS);
  localparam int VC_W      = $clog2(DEF_NUM_VCS);
  localparam int CREDIT_W  = $clog2(DEF_BUFFER_DEPTH + 1);

  typedef logic [OUTPORT_W-1:0] outport_t;
  typedef logic [INPORT_W-1:0]  inport_t;
  typedef logic [VC_W-1:0]      vc_t;
  typedef logic [CREDIT_W-1:0]  credit_t;

  // An outport carrying a multi-flit packet stays bound to the inport and VC
  // that started it until that packet's tail goes through.
  typedef struct packed {
    logic    valid;
    inport_t owner;
    vc_t     vc;
  } lock_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The search for a requester starts
// at index ptr and wraps modulo N; the first set request wins.
//
// Ports:
//   req        request vector, one bit per requester
//   ptr        index the search starts from (highest priority this cycle)
//   gnt        one-hot grant vector (all zero when nobody requests)
//   gnt_idx    index of the granted requester
//   gnt_valid  a grant was issued
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_valid
);

  localparam int IW = $clog2(N);

  int idx;

  // Walk the requesters in priority order starting at ptr. Once one has been
  // picked the rest of the walk is ignored, so the grant is always one-hot.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!gnt_valid && req[idx]) begin
        gnt_valid    = 1'b1;
        gnt_idx      = IW'(idx);
        gnt[idx]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// ---------------------------------------------------------------------------
// switch_allocator
// Per-cycle switch allocator for the chiplet switch. Arbitrates crossbar access
// per outport, holds an outport for a whole packet (wormhole) and tracks the
// downstream buffer credits per (outport, VC). Grants are combinational from
// registered state; locks, round-robin pointers and credits update on clk.
//
// Ports:
//   clk, n_rst       clock, asynchronous active-low reset
//   req_valid        inport presents a flit
//   req_outport      outport chosen by route compute
//   req_vc           VC chosen by the VC allocator
//   req_tail         flit is the last of its packet
//   grant            flit is forwarded this cycle (inport pops it)
//   xbar_valid       crossbar output drives a flit this cycle
//   xbar_sel         inport selected per outport
//   xbar_vc          VC tag of the flit on each outport
//   credit_return    downstream freed one slot for (outport, VC)
//   credit_overflow  sticky: a credit came back to an already full counter
// ---------------------------------------------------------------------------
module switch_allocator
  import switch_pkg::*;
#(
  parameter int NUM_INPORTS  = DEF_NUM_INPORTS,
  parameter int NUM_OUTPORTS = DEF_NUM_OUTPORTS,
  parameter int NUM_VCS      = DEF_NUM_VCS,
  parameter int BUFFER_DEPTH = DEF_BUFFER_DEPTH
) (
  input  logic                                                clk,
  input  logic                                                n_rst,
  input  logic [NUM_INPORTS-1:0]                              req_valid,
  input  logic [NUM_INPORTS-1:0][$clog2(NUM_OUTPORTS)-1:0]    req_outport,
  input  logic [NUM_INPORTS-1:0][$clog2(NUM_VCS)-1:0]         req_vc,
  input  logic [NUM_INPORTS-1:0]                              req_tail,
  output logic [NUM_INPORTS-1:0]                              grant,
  output logic [NUM_OUTPORTS-1:0]                             xbar_valid,
  output logic [NUM_OUTPORTS-1:0][$clog2(NUM_INPORTS)-1:0]    xbar_sel,
  output logic [NUM_OUTPORTS-1:0][$clog2(NUM_VCS)-1:0]        xbar_vc,
  input  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]                credit_return,
  output logic                                                credit_overflow
);

  localparam credit_t CREDIT_FULL = credit_t'(BUFFER_DEPTH);

  lock_t   lock_q [NUM_OUTPORTS];
  inport_t rr_ptr [NUM_OUTPORTS];
  credit_t credit [NUM_OUTPORTS][NUM_VCS];
  logic    overflow_q;

  logic [NUM_INPORTS-1:0]  arb_req [NUM_OUTPORTS];
  logic [NUM_INPORTS-1:0]  arb_gnt [NUM_OUTPORTS];
  inport_t                 arb_idx [NUM_OUTPORTS];
  logic [NUM_OUTPORTS-1:0] arb_valid;
  logic [NUM_VCS-1:0]      credit_dec [NUM_OUTPORTS];

  // Build each outport's request vector. A requester must target this outport
  // and have a downstream credit on its VC. While the outport is locked only
  // the owning inport on the owning VC may continue; everyone else waits for
  // the tail.
  always_comb begin
    arb_req = '{default: '0};
    for (int o = 0; o < NUM_OUTPORTS; o++) begin
      for (int i = 0; i < NUM_INPORTS; i++) begin
        if (req_valid[i] && req_outport[i] == outport_t'(o) &&
            credit[o][req_vc[i]] != '0) begin
          if (!lock_q[o].valid) begin
            arb_req[o][i] = 1'b1;
          end else if (inport_t'(i) == lock_q[o].owner && req_vc[i] == lock_q[o].vc) begin
            arb_req[o][i] = 1'b1;
          end
        end
      end
    end
  end

  for (genvar o = 0; o < NUM_OUTPORTS; o++) begin : g_arb
    rr_arbiter #(.N(NUM_INPORTS)) u_rr_arbiter (
      .req       (arb_req[o]),
      .ptr       (rr_ptr[o]),
      .gnt       (arb_gnt[o]),
      .gnt_idx   (arb_idx[o]),
      .gnt_valid (arb_valid[o])
    );
  end

  // Drive the crossbar and the per-inport grants. Every inport targets a single
  // outport, so OR-ing the per-outport one-hot grants never gives an inport two
  // grants. Everything is forced low while reset is held so nothing leaves the
  // switch before the state is valid.
  always_comb begin
    grant      = '0;
    xbar_valid = '0;
    xbar_sel   = '0;
    xbar_vc    = '0;
    if (n_rst) begin
      for (int o = 0; o < NUM_OUTPORTS; o++) begin
        if (arb_valid[o]) begin
          xbar_valid[o] = 1'b1;
          xbar_sel[o]   = arb_idx[o];
          xbar_vc[o]    = req_vc[arb_idx[o]];
          grant         = grant | arb_gnt[o];
        end
      end
    end
  end

  // Flag which (outport, VC) counters lose a credit to this cycle's grant.
  always_comb begin
    credit_dec = '{default: '0};
    for (int o = 0; o < NUM_OUTPORTS; o++) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        credit_dec[o][v] = xbar_valid[o] && (xbar_vc[o] == vc_t'(v));
      end
    end
  end

  // Registered state. A head flit on an unlocked outport starts a packet: it
  // takes the lock (unless it is also the tail) and moves the round-robin
  // pointer past the winner, so the pointer only moves between packets. A
  // tail always releases the lock, which lets a different inport start a new
  // packet on the very next cycle. Credits go down on a grant and up on a
  // return; both together cancel. A return to a full counter is dropped and
  // latched in the sticky overflow flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int o = 0; o < NUM_OUTPORTS; o++) begin
        lock_q[o] <= '0;
        rr_ptr[o] <= '0;
        for (int v = 0; v < NUM_VCS; v++) begin
          credit[o][v] <= CREDIT_FULL;
        end
      end
      overflow_q <= 1'b0;
    end else begin
      for (int o = 0; o < NUM_OUTPORTS; o++) begin
        if (xbar_valid[o]) begin
          if (req_tail[xbar_sel[o]]) begin
            lock_q[o].valid <= 1'b0;
          end else if (!lock_q[o].valid) begin
            lock_q[o] <= '{valid: 1'b1, owner: xbar_sel[o], vc: xbar_vc[o]};
          end
          if (!lock_q[o].valid) begin
            rr_ptr[o] <= (xbar_sel[o] == inport_t'(NUM_INPORTS - 1)) ? '0 : xbar_sel[o] + 1'b1;
          end
        end
        for (int v = 0; v < NUM_VCS; v++) begin
          case ({credit_dec[o][v], credit_return[o][v]})
            2'b10: credit[o][v] <= credit[o][v] - 1'b1;
            2'b01: begin
              if (credit[o][v] == CREDIT_FULL) begin
                overflow_q <= 1'b1;
              end else begin
                credit[o][v] <= credit[o][v] + 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign credit_overflow = overflow_q;

endmodule

// File: tb/tb_switch_allocator.sv
// ---------------------------------------------------------------------------
// tb_switch_allocator
// Self-checking bench for switch_allocator: a table of directed cycles, a set
// of hand-written multi-cycle sequences (credit exhaustion, starved VC, credit
// overflow, reset mid-packet) and a randomized run against a behavioural model.
// ---------------------------------------------------------------------------
module tb_switch_allocator;

  localparam int NI    = 4;
  localparam int NO    = 4;
  localparam int NV    = 2;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            n_rst;
  logic [3:0]      req_valid;
  logic [3:0][1:0] req_outport;
  logic [3:0][0:0] req_vc;
  logic [3:0]      req_tail;
  logic [3:0]      grant;
  logic [3:0]      xbar_valid;
  logic [3:0][1:0] xbar_sel;
  logic [3:0][0:0] xbar_vc;
  logic [3:0][1:0] credit_return;
  logic            credit_overflow;

  int errors = 0;
  int checks = 0;

  // Stimulus staging area filled by the helper tasks before each cycle.
  logic [3:0]      s_valid;
  logic [3:0][1:0] s_outp;
  logic [3:0][0:0] s_vc;
  logic [3:0]      s_tail;
  logic [3:0][1:0] s_cret;

  typedef struct {
    string           name;
    logic [3:0]      valid;
    logic [3:0][1:0] outp;
    logic [3:0][0:0] vc;
    logic [3:0]      tail;
    logic [3:0][1:0] cret;
    logic [3:0]      e_grant;
    logic [3:0]      e_xv;
    logic [3:0][1:0] e_sel;
    logic [3:0][0:0] e_vc;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model state for the randomized run.
  int  m_cred [NO][NV];
  int  m_lock [NO];
  int  m_lockvc [NO];
  int  m_ptr [NO];
  bit  m_ovf;
  bit  p_act [NI];
  int  p_out [NI];
  int  p_vc [NI];
  int  p_rem [NI];

  always #5 clk = ~clk;

  switch_allocator #(
    .NUM_INPORTS  (NI),
    .NUM_OUTPORTS (NO),
    .NUM_VCS      (NV),
    .BUFFER_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .req_valid       (req_valid),
    .req_outport     (req_outport),
    .req_vc          (req_vc),
    .req_tail        (req_tail),
    .grant           (grant),
    .xbar_valid      (xbar_valid),
    .xbar_sel        (xbar_sel),
    .xbar_vc         (xbar_vc),
    .credit_return   (credit_return),
    .credit_overflow (credit_overflow)
  );

  function automatic vec_t mk(string name, logic [3:0] valid, logic [3:0][1:0] outp,
                              logic [3:0][0:0] vc, logic [3:0] tail, logic [3:0][1:0] cret,
                              logic [3:0] eg, logic [3:0] exv, logic [3:0][1:0] esel,
                              logic [3:0][0:0] evc);
    vec_t r;
    r.name = name; r.valid = valid; r.outp = outp; r.vc = vc; r.tail = tail; r.cret = cret;
    r.e_grant = eg; r.e_xv = exv; r.e_sel = esel; r.e_vc = evc;
    return r;
  endfunction

  task automatic clearStim();
    s_valid = '0; s_outp = '0; s_vc = '0; s_tail = '0; s_cret = '0;
  endtask

  task automatic setReq(input int i, input int o, input int v, input bit t);
    s_valid[i] = 1'b1;
    s_outp[i]  = 2'(o);
    s_vc[i]    = 1'(v);
    s_tail[i]  = t;
  endtask

  // Drive the staged inputs just after the falling edge and let the
  // combinational outputs settle before anyone looks at them.
  task automatic applyStimulus();
    @(negedge clk);
    req_valid     = s_valid;
    req_outport   = s_outp;
    req_vc        = s_vc;
    req_tail      = s_tail;
    credit_return = s_cret;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eg, input logic [3:0] exv,
                             input logic [3:0][1:0] esel, input logic [3:0][0:0] evc,
                             input logic eovf);
    bit sel_ok;
    sel_ok = 1'b1;
    checks++;
    if (grant !== eg) begin
      errors++;
      $display("[TB] FAIL %s grant: got %b want %b", name, grant, eg);
    end
    checks++;
    if (xbar_valid !== exv) begin
      errors++;
      $display("[TB] FAIL %s xbar_valid: got %b want %b", name, xbar_valid, exv);
    end
    if (exv != '0) begin
      for (int o = 0; o < NO; o++) begin
        if (exv[o] && (xbar_sel[o] !== esel[o] || xbar_vc[o] !== evc[o])) sel_ok = 1'b0;
      end
      checks++;
      if (!sel_ok) begin
        errors++;
        $display("[TB] FAIL %s xbar_sel/vc: got sel=%h vc=%b want sel=%h vc=%b (mask %b)",
                 name, xbar_sel, xbar_vc, esel, evc, exv);
      end
    end
    checks++;
    if (credit_overflow !== eovf) begin
      errors++;
      $display("[TB] FAIL %s credit_overflow: got %b want %b", name, credit_overflow, eovf);
    end
  endtask

  task automatic expectOne(input string name, input int i, input int o, input int v, input logic ovf);
    logic [3:0]      eg  = '0;
    logic [3:0]      exv = '0;
    logic [3:0][1:0] es  = '0;
    logic [3:0][0:0] ev  = '0;
    eg[i]  = 1'b1;
    exv[o] = 1'b1;
    es[o]  = 2'(i);
    ev[o]  = 1'(v);
    checkOutput(name, eg, exv, es, ev, ovf);
  endtask

  task automatic expectNone(input string name, input logic ovf);
    checkOutput(name, 4'b0, 4'b0, '0, '0, ovf);
  endtask

  // Assert reset in the middle of a cycle with live requests on the inputs:
  // every output must drop immediately and stay low while reset is held.
  task automatic doReset(input string name);
    clearStim();
    setReq(0, 1, 0, 1'b1);
    setReq(2, 3, 1, 1'b0);
    req_valid = s_valid; req_outport = s_outp; req_vc = s_vc;
    req_tail = s_tail; credit_return = s_cret;
    n_rst = 1'b0;
    #1;
    checkOutput(name, 4'b0, 4'b0, '0, '0, 1'b0);
    checks++;
    if (xbar_sel !== '0 || xbar_vc !== '0) begin
      errors++;
      $display("[TB] FAIL %s xbar_sel/vc in reset: got sel=%h vc=%b want 0", name, xbar_sel, xbar_vc);
    end
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    clearStim();
    req_valid = '0; req_outport = '0; req_vc = '0; req_tail = '0; credit_return = '0;
  endtask

  task automatic modelReset();
    for (int o = 0; o < NO; o++) begin
      m_lock[o] = -1; m_lockvc[o] = 0; m_ptr[o] = 0;
      for (int v = 0; v < NV; v++) m_cred[o][v] = DEPTH;
    end
    m_ovf = 1'b0;
    for (int i = 0; i < NI; i++) p_act[i] = 1'b0;
  endtask

  task automatic randomRun(input int cycles);
    logic [3:0]      eg;
    logic [3:0]      exv;
    logic [3:0][1:0] es;
    logic [3:0][0:0] ev;
    int              winner [NO];
    int              best_d;
    int              d;
    bit              dec;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < NI; i++) begin
        if (!p_act[i] && $urandom_range(0, 1) == 1) begin
          p_act[i] = 1'b1;
          p_out[i] = $urandom_range(0, NO - 1);
          p_vc[i]  = $urandom_range(0, NV - 1);
          p_rem[i] = $urandom_range(1, 4);
        end
      end
      clearStim();
      for (int i = 0; i < NI; i++) if (p_act[i]) setReq(i, p_out[i], p_vc[i], p_rem[i] == 1);
      for (int o = 0; o < NO; o++)
        for (int v = 0; v < NV; v++)
          s_cret[o][v] = ($urandom_range(0, 3) == 0) &&
                         (m_cred[o][v] < DEPTH || $urandom_range(0, 19) == 0);
      applyStimulus();

      // Winner per outport: the eligible inport closest to the pointer,
      // counting forward with wrap-around.
      eg = '0; exv = '0; es = '0; ev = '0;
      for (int o = 0; o < NO; o++) begin
        winner[o] = -1;
        best_d    = NI;
        for (int i = 0; i < NI; i++) begin
          if (p_act[i] && p_out[i] == o && m_cred[o][p_vc[i]] > 0 &&
              (m_lock[o] < 0 || (m_lock[o] == i && m_lockvc[o] == p_vc[i]))) begin
            d = (i - m_ptr[o] + NI) % NI;
            if (d < best_d) begin best_d = d; winner[o] = i; end
          end
        end
        if (winner[o] >= 0) begin
          eg[winner[o]] = 1'b1;
          exv[o]        = 1'b1;
          es[o]         = 2'(winner[o]);
          ev[o]         = 1'(p_vc[winner[o]]);
        end
      end
      checkOutput($sformatf("rand_c%0d", c), eg, exv, es, ev, m_ovf);

      for (int o = 0; o < NO; o++) begin
        for (int v = 0; v < NV; v++) begin
          dec = (winner[o] >= 0) && (p_vc[winner[o]] == v);
          if (dec && !s_cret[o][v]) m_cred[o][v]--;
          else if (!dec && s_cret[o][v]) begin
            if (m_cred[o][v] == DEPTH) m_ovf = 1'b1;
            else m_cred[o][v]++;
          end
        end
        if (winner[o] >= 0) begin
          if (m_lock[o] < 0) m_ptr[o] = (winner[o] + 1) % NI;
          if (p_rem[winner[o]] == 1) m_lock[o] = -1;
          else if (m_lock[o] < 0) begin
            m_lock[o]   = winner[o];
            m_lockvc[o] = p_vc[winner[o]];
          end
          p_rem[winner[o]]--;
          if (p_rem[winner[o]] == 0) p_act[winner[o]] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_rst = 1'b0;
    clearStim();
    req_valid = '0; req_outport = '0; req_vc = '0; req_tail = '0; credit_return = '0;
    @(negedge clk);
    doReset("reset_initial");

    // Directed cycles straight after reset: single flit, round robin on a
    // shared outport, a 3-flit wormhole packet, and a VC-specific lock.
    vecs.push_back(mk("single_out2",   4'b0001, {2'd0,2'd0,2'd0,2'd2}, 4'b0001, 4'b0001, 8'h00,
                      4'b0001, 4'b0100, {2'd0,2'd0,2'd0,2'd0}, 4'b0100));
    vecs.push_back(mk("rr_first",      4'b1011, {2'd1,2'd0,2'd1,2'd1}, 4'b0000, 4'b1011, 8'h00,
                      4'b0001, 4'b0010, {2'd0,2'd0,2'd0,2'd0}, 4'b0000));
    vecs.push_back(mk("rr_second",     4'b1011, {2'd1,2'd0,2'd1,2'd1}, 4'b0000, 4'b1011, 8'h00,
                      4'b0010, 4'b0010, {2'd0,2'd0,2'd1,2'd0}, 4'b0000));
    vecs.push_back(mk("rr_third",      4'b1011, {2'd1,2'd0,2'd1,2'd1}, 4'b0000, 4'b1011, 8'h00,
                      4'b1000, 4'b0010, {2'd0,2'd0,2'd3,2'd0}, 4'b0000));
    vecs.push_back(mk("rr_wrap",       4'b1011, {2'd1,2'd0,2'd1,2'd1}, 4'b0000, 4'b1011, 8'h00,
                      4'b0001, 4'b0010, {2'd0,2'd0,2'd0,2'd0}, 4'b0000));
    vecs.push_back(mk("worm_head",     4'b0100, {2'd0,2'd0,2'd0,2'd0}, 4'b0000, 4'b0000, 8'h00,
                      4'b0100, 4'b0001, {2'd0,2'd0,2'd0,2'd2}, 4'b0000));
    vecs.push_back(mk("worm_body",     4'b0111, {2'd0,2'd0,2'd0,2'd3}, 4'b0001, 4'b0011, 8'h00,
                      4'b0101, 4'b1001, {2'd0,2'd0,2'd0,2'd2}, 4'b1000));
    vecs.push_back(mk("worm_tail",     4'b0110, {2'd0,2'd0,2'd0,2'd0}, 4'b0000, 4'b0110, 8'b0010_0000,
                      4'b0100, 4'b0001, {2'd0,2'd0,2'd0,2'd2}, 4'b0000));
    vecs.push_back(mk("after_tail",    4'b0010, {2'd0,2'd0,2'd0,2'd0}, 4'b0000, 4'b0010, 8'h00,
                      4'b0010, 4'b0001, {2'd0,2'd0,2'd0,2'd1}, 4'b0000));
    vecs.push_back(mk("lock_vc0_head", 4'b1000, {2'd2,2'd0,2'd0,2'd0}, 4'b0000, 4'b0000, 8'h00,
                      4'b1000, 4'b0100, {2'd0,2'd3,2'd0,2'd0}, 4'b0000));
    vecs.push_back(mk("locked_block",  4'b0001, {2'd0,2'd0,2'd0,2'd2}, 4'b0001, 4'b0001, 8'h00,
                      4'b0000, 4'b0000, {2'd0,2'd0,2'd0,2'd0}, 4'b0000));
    vecs.push_back(mk("lock_release",  4'b1001, {2'd2,2'd0,2'd0,2'd2}, 4'b0001, 4'b1001, 8'h00,
                      4'b1000, 4'b0100, {2'd0,2'd3,2'd0,2'd0}, 4'b0000));
    vecs.push_back(mk("after_release", 4'b0001, {2'd0,2'd0,2'd0,2'd2}, 4'b0001, 4'b0001, 8'h00,
                      4'b0001, 4'b0100, {2'd0,2'd0,2'd0,2'd0}, 4'b0100));

    foreach (vecs[k]) begin
      s_valid = vecs[k].valid; s_outp = vecs[k].outp; s_vc = vecs[k].vc;
      s_tail = vecs[k].tail; s_cret = vecs[k].cret;
      applyStimulus();
      checkOutput(vecs[k].name, vecs[k].e_grant, vecs[k].e_xv, vecs[k].e_sel, vecs[k].e_vc, 1'b0);
    end

    // Credit exhaustion on out 3 VC0, return timing, and grant+return cancel.
    doReset("reset_credit");
    clearStim();
    setReq(1, 3, 0, 1'b1);
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus();
      expectOne($sformatf("drain_%0d", k), 1, 3, 0, 1'b0);
    end
    applyStimulus();
    expectNone("stall_9th", 1'b0);
    s_cret[3][0] = 1'b1;
    applyStimulus();
    expectNone("return_cycle", 1'b0);
    s_cret = '0;
    applyStimulus();
    expectOne("grant_after_return", 1, 3, 0, 1'b0);
    s_cret[3][0] = 1'b1;
    applyStimulus();
    expectNone("second_return", 1'b0);
    applyStimulus();
    expectOne("grant_and_return", 1, 3, 0, 1'b0);
    s_cret = '0;
    applyStimulus();
    expectOne("credit_kept", 1, 3, 0, 1'b0);
    applyStimulus();
    expectNone("empty_again", 1'b0);

    // Out 1: VC0 drained to 0, VC1 left at 5; only the VC1 requester may go.
    doReset("reset_starve");
    clearStim();
    setReq(2, 1, 0, 1'b1);
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus();
      expectOne($sformatf("starve_vc0_%0d", k), 2, 1, 0, 1'b0);
    end
    clearStim();
    setReq(3, 1, 1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus();
      expectOne($sformatf("starve_vc1_%0d", k), 3, 1, 1, 1'b0);
    end
    clearStim();
    setReq(0, 1, 0, 1'b1);
    setReq(1, 1, 1, 1'b1);
    applyStimulus();
    expectOne("starved_vc_only_vc1", 1, 1, 1, 1'b0);

    // Return to a full counter: flag sets and the count stays at DEPTH.
    doReset("reset_ovf");
    clearStim();
    s_cret[0][0] = 1'b1;
    applyStimulus();
    expectNone("ovf_return", 1'b0);
    clearStim();
    applyStimulus();
    expectNone("ovf_set", 1'b1);
    setReq(3, 0, 0, 1'b1);
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus();
      expectOne($sformatf("ovf_drain_%0d", k), 3, 0, 0, 1'b1);
    end
    applyStimulus();
    expectNone("ovf_count_stayed_full", 1'b1);

    // Reset in the middle of a packet: lock abandoned, credits restored.
    doReset("reset_clears_ovf");
    clearStim();
    setReq(1, 3, 0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus();
      expectOne($sformatf("pre_drain_%0d", k), 1, 3, 0, 1'b0);
    end
    clearStim();
    setReq(2, 0, 1, 1'b0);
    applyStimulus();
    expectOne("mid_head", 2, 0, 1, 1'b0);
    applyStimulus();
    expectOne("mid_body", 2, 0, 1, 1'b0);
    doReset("reset_mid_packet");
    clearStim();
    setReq(0, 0, 0, 1'b1);
    applyStimulus();
    expectOne("lock_cleared", 0, 0, 0, 1'b0);
    clearStim();
    setReq(1, 3, 0, 1'b1);
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus();
      expectOne($sformatf("post_reset_drain_%0d", k), 1, 3, 0, 1'b0);
    end
    applyStimulus();
    expectNone("post_reset_stall", 1'b0);

    // Randomized traffic against the behavioural model.
    doReset("reset_random");
    modelReset();
    randomRun(2500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/switch_allocator.md
# switch_allocator

Per-cycle switch allocator for the chiplet switch. It sits directly downstream of the VC allocator. Each inport presents its head-of-buffer flit with the outport from route compute and the VC assigned by the VC allocator. The block arbitrates crossbar access per outport, holds an outport for the whole packet (wormhole), and tracks downstream buffer credits per (outport, VC). Grants are combinational from registered state; all state updates on the clock edge.

## Interface

Parameters:
- NUM_INPORTS, 4, number of input ports
- NUM_OUTPORTS, 4, number of output ports
- NUM_VCS, 2, VCs per link (same on every link)
- BUFFER_DEPTH, 8, downstream flit buffer depth per VC; this is the initial credit value

Ports:
- clk  input  1  clock
- n_rst  input  1  reset; asynchronous, active-low
- req_valid  input  [NUM_INPORTS]  inport has a flit requesting the crossbar
- req_outport  input  [NUM_INPORTS][$clog2(NUM_OUTPORTS)]  requested outport
- req_vc  input  [NUM_INPORTS][$clog2(NUM_VCS)]  assigned VC from the VC allocator
- req_tail  input  [NUM_INPORTS]  flit is the last of its packet; a single-flit packet has req_tail=1
- grant  output  [NUM_INPORTS]  flit is forwarded this cycle; the inport pops it
- xbar_valid  output  [NUM_OUTPORTS]  crossbar output drives a flit this cycle
- xbar_sel  output  [NUM_OUTPORTS][$clog2(NUM_INPORTS)]  selected inport per outport
- xbar_vc  output  [NUM_OUTPORTS][$clog2(NUM_VCS)]  VC tag for the flit on each outport
- credit_return  input  [NUM_OUTPORTS][NUM_VCS]  downstream freed one buffer slot
- credit_overflow  output  1  sticky error flag: a credit was returned while the counter was already full

## Operation

- State per outport o:
  - lock_valid[o], lock_owner[o], lock_vc[o]
  - rr_ptr[o], an inport index
  - credit[o][v], width $clog2(BUFFER_DEPTH+1)
- Eligible requester for outport o: req_valid[i], req_outport[i]==o, and credit[o][req_vc[i]] != 0.
- Locked outport: the only eligible requester is i==lock_owner[o] with req_vc[i]==lock_vc[o]. All other requesters are blocked.
- Unlocked outport: round-robin grant among eligible requesters. Search starts at rr_ptr[o] and wraps modulo NUM_INPORTS.
- Grant to inport i on outport o drives:
  - grant[i]=1
  - xbar_valid[o]=1
  - xbar_sel[o]=i
  - xbar_vc[o]=req_vc[i]
- Each inport requests one outport, so grant is at most one-hot per outport and at most one per inport.
- Lock update on grant:
  - Non-tail flit on an unlocked outport: set lock_valid, lock_owner=i, lock_vc=req_vc[i].
  - Tail flit: clear lock_valid.
  - Single-flit packet: never locks.
- rr_ptr[o] advances to (grantee+1) mod NUM_INPORTS only when a packet starts, i.e. on a grant while unlocked.
- Credit update per (o,v): next = credit − (granted flit on o,v) + credit_return[o][v].
  - Simultaneous decrement and return leaves the counter unchanged.
  - A return when credit==BUFFER_DEPTH with no decrement is dropped and sets credit_overflow. The flag clears only on reset.
  - Underflow cannot occur: a grant requires credit != 0.
- Inports must hold their request stable until granted. A change to a held request is a protocol error with undefined result.

## Timing

- Request to grant: 0 cycles, combinational in the same cycle.
- Lock, pointer and credit changes take effect in the cycle after the grant.
- A credit returned in cycle N makes a blocked requester eligible in cycle N+1.
- Back-to-back packets from different inports to one outport: the tail is granted in cycle N; the next head can be granted in cycle N+1 with no bubble.
- Reset, asynchronous and taking effect immediately:
  - all locks cleared, rr_ptr=0, credit=BUFFER_DEPTH, credit_overflow=0
  - grant, xbar_valid, xbar_sel and xbar_vc are all 0 while n_rst is low
  - Reset during a packet abandons its lock; upstream buffers are reset by the same n_rst.

## Structure

- Shared package switch_pkg holds:
  - typedefs outport_t, inport_t, vc_t, credit_t, sized from the parameters above
  - the lock-state struct (valid, owner, vc)
- Sub-module rr_arbiter:
  - parameter N
  - inputs: req[N], ptr
  - outputs: gnt[N] one-hot, gnt_idx, gnt_valid
  - purely combinational
  - one instance per outport

## Test plan

- Reset, then inport 0 sends a single flit to out 2 on VC1 → grant[0]=1, xbar_sel[2]=0, xbar_vc[2]=1 in the same cycle. Next cycle credit[2][1]=7 and out 2 is unlocked.
- Inports 0, 1 and 3 all hold single-flit requests to out 1 → grants go to 0, 1, 3, 0 in successive cycles, one per cycle.
- Inport 2 sends a 3-flit packet to out 0 while inport 1 also requests out 0 → inport 2 wins all 3 cycles and inport 1 is granted the cycle after the tail.
- Eight single-flit grants to out 3 VC0 with no returns → the 9th request stalls. credit_return[3][0] pulsed in cycle N → grant in N+1. Grant plus return in the same cycle → counter unchanged.
- VC0 on out 1 has 0 credits and VC1 has 5; inport 0 requests VC0 and inport 1 requests VC1 → only inport 1 is granted.
- Return a credit on a full counter → credit_overflow=1 and the count stays at 8. Assert n_rst mid-packet → lock cleared, all counters back to 8, outputs 0 immediately.
